// File: rtl/seq_mult_param.sv
`default_nettype none
// ============================================================================
// Module     : seq_mult_param
// Description: Multi-cycle shift-add multiplier, signed/unsigned per operation,
//              2*WIDTH-bit product on hi/lo. Define MULT_OVF_EN to add ovf.
// Revision   : 1.0
// ============================================================================
module seq_mult_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MULT_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_prod;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;
  logic                 w_last;

  // Magnitude of the most-negative value wraps to 2^(WIDTH-1), which is correct unsigned.
  assign w_mag_a  = (is_signed && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (is_signed && b[WIDTH-1]) ? -b : b;
  assign w_sum    = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_last   = (r_cnt == CNT_W'(WIDTH));
  assign w_res    = r_neg ? -r_prod : r_prod;
  assign w_res_hi = w_res[2*WIDTH-1:WIDTH];
  assign w_res_lo = w_res[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef MULT_OVF_EN
  logic r_sgn;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef MULT_OVF_EN
      r_sgn   <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= w_mag_a;
            r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
            r_cnt   <= '0;
            r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULT_OVF_EN
            r_sgn   <= is_signed;
`endif
          end
        end
        S_RUN: begin
          if (w_last) begin
            hi  <= w_res_hi;
            lo  <= w_res_lo;
`ifdef MULT_OVF_EN
            ovf <= r_sgn ? (w_res_hi != {WIDTH{w_res_lo[WIDTH-1]}}) : (w_res_hi != '0);
`endif
          end else begin
            // Carry of the partial sum shifts into the product MSB.
            r_prod <= {w_sum, r_prod[WIDTH-1:1]};
            r_cnt  <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_param.sv
`default_nettype none
// Testbench for seq_mult_param: WIDTH=32 and WIDTH=8 instances, directed vectors
// plus handshake, stray-start, reset and back-to-back sequences.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, sgn32, start8, sgn8;
  logic [31:0] a32, b32, hi32, lo32;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy32, done32, busy8, done8;
`ifdef MULT_OVF_EN
  logic        ovf32, ovf8;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .is_signed(sgn32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
`ifdef MULT_OVF_EN
    , .ovf(ovf32)
`endif
  );

  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
`ifdef MULT_OVF_EN
    , .ovf(ovf8)
`endif
  );

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          ovf;
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Present operands with start, let one edge capture them, then drop start.
  task automatic launch(input bit w8, input bit sgn, input logic [31:0] av, input logic [31:0] bv);
    if (w8) begin
      start8 = 1'b1; sgn8 = sgn; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start32 = 1'b1; sgn32 = sgn; a32 = av; b32 = bv;
    end
    @(posedge clk); #1;
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  // Waits for done, checks latency, busy throughout and single-cycle done.
  task automatic wait_done(input bit w8, input int lat, input string nm);
    int  cyc;
    bit  busy_low;
    logic bz, dn;
    cyc = 0; busy_low = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bz = w8 ? busy8 : busy32;
      dn = w8 ? done8 : done32;
      if (!bz) busy_low = 1;
      if (dn || cyc >= 200) break;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(lat));
    chk({nm, "_busy_held"}, 64'(busy_low), 64'd0);
    @(posedge clk); #1;
    dn = w8 ? done8 : done32;
    bz = w8 ? busy8 : busy32;
    chk({nm, "_done_pulse"}, {62'd0, dn, bz}, 64'd0);
  endtask

  initial begin
    int  ndone;
    bit  stray_armed;

    tv[0]  = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1};
    tv[1]  = '{1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 0};
    tv[2]  = '{1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1};
    tv[3]  = '{0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 0};
    tv[4]  = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0};
    tv[5]  = '{0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1};
    tv[6]  = '{1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 0};
    tv[7]  = '{0, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 1};
    tv[8]  = '{1, 32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, 1};
    tv[9]  = '{0, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1, 1};
    tv[10] = '{1, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 0};

    rst = 1'b1;
    start32 = 0; sgn32 = 0; a32 = 0; b32 = 0;
    start8 = 0; sgn8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl32", {62'd0, busy32, done32}, 64'd0);
    chk("reset_prod32", {hi32, lo32}, 64'd0);
    chk("reset_ctrl8", {62'd0, busy8, done8}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      launch(0, tv[i].sgn, tv[i].a, tv[i].b);
      wait_done(0, 33, $sformatf("v%0d", i));
      chk($sformatf("v%0d_hi", i), 64'(hi32), 64'(tv[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(lo32), 64'(tv[i].lo));
`ifdef MULT_OVF_EN
      chk($sformatf("v%0d_ovf", i), 64'(ovf32), 64'(tv[i].ovf));
`endif
    end

    // 7*6 with stray starts during RUN and DONE, and operand churn mid-run.
    launch(0, 0, 32'd7, 32'd6);
    ndone = 0; stray_armed = 0;
    for (int cyc = 1; cyc <= 70; cyc++) begin
      @(posedge clk); #1;
      if (stray_armed) begin
        start32 = 0; stray_armed = 0;
      end
      if (cyc == 5) begin
        start32 = 1; a32 = 32'd1; b32 = 32'd1; sgn32 = 1;
      end
      if (cyc == 6) begin
        start32 = 0; a32 = 32'd3; b32 = 32'd9;
      end
      if (done32) begin
        ndone++;
        if (ndone == 1) begin
          chk("stray_lo", 64'(lo32), 64'd42);
          chk("stray_hi", 64'(hi32), 64'd0);
          start32 = 1; a32 = 32'd1; b32 = 32'd1;
          stray_armed = 1;
        end
      end
    end
    chk("stray_done_count", 64'(ndone), 64'd1);
    chk("stray_idle", {62'd0, busy32, done32}, 64'd0);
    chk("stray_hold", {hi32, lo32}, 64'd42);

    // Reset ten cycles into an operation.
    launch(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ctrl", {62'd0, busy32, done32}, 64'd0);
    chk("midrst_prod", {hi32, lo32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // WIDTH=8 signed most-negative, then immediate back-to-back start.
    launch(1, 1, 32'h80, 32'h01);
    wait_done(1, 9, "w8_neg");
    chk("w8_neg_prod", {hi8, lo8}, 16'hFF80);
`ifdef MULT_OVF_EN
    chk("w8_neg_ovf", 64'(ovf8), 64'd0);
`endif
    launch(1, 0, 32'd3, 32'd5);
    chk("w8_b2b_accepted", 64'(busy8), 64'd1);
    wait_done(1, 9, "w8_b2b");
    chk("w8_b2b_prod", {hi8, lo8}, 16'h000F);
    launch(1, 1, 32'hF0, 32'hF0);
    wait_done(1, 9, "w8_sq");
    chk("w8_sq_prod", {hi8, lo8}, 16'h0100);
`ifdef MULT_OVF_EN
    chk("w8_sq_ovf", 64'(ovf8), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
